inst_axi_bridge: RTL and testbench

Instruction-side responder for the core's fetch port. It accepts the word address and enable driven by the PC stage and returns the instruction word through a one-entry fetch buffer. On a buffer miss it stalls the pipeline and performs a single AXI4-Lite read on the SoC instruction bus. It sits between the PC stage and the AXI-Lite interconnect.

---
 rtl/inst_axi_bridge_pkg.sv | 21 ++
 rtl/inst_axi_bridge_addr_map.sv | 23 ++
 rtl/inst_axi_bridge.sv | 145 ++++++++++++++
 tb/tb_inst_axi_bridge.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_axi_bridge_pkg.sv
// Shared AXI-Lite codes and fetch-FSM state type for the instruction-side bridge
// and the future data-side bridge.
package inst_axi_bridge_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] ARPROT_INST = 3'b100;

    // Top two VA bits selecting the unmapped kseg0/kseg1 windows
    localparam logic [1:0] KSEG01_TOP = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/inst_axi_bridge_addr_map.sv
// Combinational kseg0/kseg1 virtual-to-physical translation; result is word aligned.
module inst_addr_map
    import inst_axi_bridge_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] i_va,
    output logic [ADDR_W-1:0] o_pa
);

    localparam logic [ADDR_W-1:0] PA_WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    logic [ADDR_W-1:0] w_pa_raw;

    always_comb begin
        w_pa_raw = i_va;
        if (i_va[ADDR_W-1 -: 2] == KSEG01_TOP) begin
            w_pa_raw = {3'b000, i_va[ADDR_W-4:0]};
        end
        o_pa = w_pa_raw & PA_WORD_MASK;
    end

endmodule

// File: rtl/inst_axi_bridge.sv
// Instruction fetch responder: one-entry fetch buffer refilled by a single AXI4-Lite read.
// Optional bus-error tagging of the buffered word is enabled by defining FETCH_ERR_EN.
module inst_axi_bridge
    import inst_axi_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rom_en,
    input  logic [ADDR_W-1:0] rom_addr,
    output logic [DATA_W-1:0] inst_o,
    output logic              inst_valid_o,
    output logic              stall_req,
    output logic [ADDR_W-1:0] araddr,
    output logic [2:0]        arprot,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic              fetch_err_o
);

    fetch_state_t r_state, w_state_nxt;

    logic [ADDR_W-1:2] r_req_addr, w_req_addr_nxt;
    logic [ADDR_W-1:0] r_araddr,   w_araddr_nxt;
    logic              r_arvalid,  w_arvalid_nxt;
    logic              r_rready,   w_rready_nxt;
    logic              w_fill;

    logic [ADDR_W-1:2] r_tag_addr;
    logic              r_tag_valid;
    logic [DATA_W-1:0] r_data;

    logic [ADDR_W-1:0] w_pa;
    logic              w_hit;

    inst_addr_map #(
        .ADDR_W (ADDR_W)
    ) u_addr_map (
        .i_va (rom_addr),
        .o_pa (w_pa)
    );

    assign w_hit        = r_tag_valid && (r_tag_addr == rom_addr[ADDR_W-1:2]);
    assign inst_valid_o = rom_en & w_hit;
    assign stall_req    = rom_en & ~w_hit;
    assign inst_o       = r_data;

    assign araddr  = r_araddr;
    assign arvalid = r_arvalid;
    assign rready  = r_rready;
    assign arprot  = ARPROT_INST;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_req_addr <= '0;
            r_araddr   <= '0;
            r_arvalid  <= 1'b0;
            r_rready   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_req_addr <= w_req_addr_nxt;
            r_araddr   <= w_araddr_nxt;
            r_arvalid  <= w_arvalid_nxt;
            r_rready   <= w_rready_nxt;
        end
    end

    // A redirect mid-read does not abort: the word fills under the latched request tag
    always_comb begin
        w_state_nxt    = r_state;
        w_req_addr_nxt = r_req_addr;
        w_araddr_nxt   = r_araddr;
        w_arvalid_nxt  = r_arvalid;
        w_rready_nxt   = r_rready;
        w_fill         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (stall_req) begin
                    w_req_addr_nxt = rom_addr[ADDR_W-1:2];
                    w_araddr_nxt   = w_pa;
                    w_arvalid_nxt  = 1'b1;
                    w_state_nxt    = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (arready) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_state_nxt   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (rvalid) begin
                    w_rready_nxt = 1'b0;
                    w_fill       = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end
            end
            default: begin
                w_arvalid_nxt = 1'b0;
                w_rready_nxt  = 1'b0;
                w_state_nxt   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tag_valid <= 1'b0;
            r_tag_addr  <= '0;
            r_data      <= '0;
        end else if (w_fill) begin
            r_tag_valid <= 1'b1;
            r_tag_addr  <= r_req_addr;
            r_data      <= rdata;
        end
    end

`ifdef FETCH_ERR_EN
    logic r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_fill) begin
            r_err <= (rresp != RESP_OKAY);
        end
    end

    assign fetch_err_o = inst_valid_o & r_err;
`else
    logic w_unused_rresp;

    assign w_unused_rresp = ^rresp;
    assign fetch_err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_inst_axi_bridge.sv
// Directed bench for inst_axi_bridge: table of fetches against a cycle-driven AXI slave,
// plus hand sequences for buffer hold, redirect, reset mid-read and bus errors.
module tb_inst_axi_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_en;
    logic [31:0] rom_addr;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        stall_req;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        fetch_err_o;

    int checks = 0;
    int errors = 0;

`ifdef FETCH_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    inst_axi_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .rom_en       (rom_en),
        .rom_addr     (rom_addr),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o),
        .stall_req    (stall_req),
        .araddr       (araddr),
        .arprot       (arprot),
        .arvalid      (arvalid),
        .arready      (arready),
        .rdata        (rdata),
        .rresp        (rresp),
        .rvalid       (rvalid),
        .rready       (rready),
        .fetch_err_o  (fetch_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] va;
        logic [31:0] data;
        int          arw;
        int          rw;
        logic [31:0] pa;
        int          stall;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Presents addr from the next negedge and acts as the slave until stall_req drops.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp,
                         input int arw, input int rw, input logic [31:0] exp_pa,
                         input int exp_stall, input logic exp_err);
        int ar_seen = 0;
        int r_seen  = 0;
        int stalls  = 0;
        bit done    = 1'b0;
        @(negedge clk);
        rom_en   = 1'b1;
        rom_addr = addr;
        for (int c = 0; c < 100 && !done; c++) begin
            arready = 1'b0;
            rvalid  = 1'b0;
            if (arvalid) begin
                ar_seen++;
                chk("araddr_stable", araddr, exp_pa);
                chk("rready_outside_data", {31'd0, rready}, 32'd0);
                if (ar_seen > arw) arready = 1'b1;
            end
            if (rready) begin
                r_seen++;
                if (r_seen > rw) begin
                    rvalid = 1'b1;
                    rdata  = data;
                    rresp  = resp;
                end
            end
            #1;
            if (stall_req) begin
                stalls++;
                @(negedge clk);
            end else begin
                done = 1'b1;
            end
        end
        arready = 1'b0;
        rvalid  = 1'b0;
        rdata   = '0;
        rresp   = 2'b00;
        chk("fetch_completes", {31'd0, done}, 32'd1);
        chk("stall_cycles", stalls, exp_stall);
        chk("inst_valid_after_fill", {31'd0, inst_valid_o}, 32'd1);
        chk("inst_after_fill", inst_o, data);
        chk("fetch_err", {31'd0, fetch_err_o}, {31'd0, exp_err});
    endtask

    initial begin
        int saw;
        tbl[0] = '{va: 32'hbfc00000, data: 32'h3c080001, arw: 0, rw: 0, pa: 32'h1fc00000, stall: 3};
        tbl[1] = '{va: 32'hbfc00004, data: 32'h24090002, arw: 4, rw: 3, pa: 32'h1fc00004, stall: 10};
        tbl[2] = '{va: 32'h80000180, data: 32'h8d2a0000, arw: 1, rw: 0, pa: 32'h00000180, stall: 4};
        tbl[3] = '{va: 32'h00400003, data: 32'h11111111, arw: 0, rw: 2, pa: 32'h00400000, stall: 5};
        tbl[4] = '{va: 32'hc0001000, data: 32'h22222222, arw: 0, rw: 0, pa: 32'hc0001000, stall: 3};
        tbl[5] = '{va: 32'ha0000ffc, data: 32'hdeadbeef, arw: 2, rw: 1, pa: 32'h00000ffc, stall: 6};

        rst      = 1'b0;
        rom_en   = 1'b0;
        rom_addr = 32'hbfc00000;
        arready  = 1'b0;
        rvalid   = 1'b0;
        rdata    = '0;
        rresp    = 2'b00;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
        chk("rst_araddr", araddr, 32'd0);
        chk("rst_rready", {31'd0, rready}, 32'd0);
        chk("rst_inst_o", inst_o, 32'd0);
        chk("rst_inst_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        chk("rst_fetch_err", {31'd0, fetch_err_o}, 32'd0);
        chk("arprot", {29'd0, arprot}, 32'd4);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            fetch(tbl[i].va, tbl[i].data, 2'b00, tbl[i].arw, tbl[i].rw, tbl[i].pa, tbl[i].stall, 1'b0);
        end

        // Held address after fill: no new read, no stall
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("hold_arvalid", {31'd0, arvalid}, 32'd0);
            chk("hold_stall", {31'd0, stall_req}, 32'd0);
            chk("hold_inst", inst_o, 32'hdeadbeef);
        end

        // Fetch disabled on a missing address: no request
        rom_en   = 1'b0;
        rom_addr = 32'h12345678;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            chk("dis_stall", {31'd0, stall_req}, 32'd0);
            chk("dis_inst_valid", {31'd0, inst_valid_o}, 32'd0);
            chk("dis_arvalid", {31'd0, arvalid}, 32'd0);
        end

        // Redirect while in DATA
        @(negedge clk);
        rom_en   = 1'b1;
        rom_addr = 32'hbfc00004;
        saw = 0;
        for (int c = 0; c < 50 && saw == 0; c++) begin
            arready = 1'b0;
            rvalid  = 1'b0;
            if (arvalid) begin
                chk("redir_araddr", araddr, 32'h1fc00004);
                arready = 1'b1;
            end
            if (rready) begin
                rom_addr = 32'h80000180;
                rvalid   = 1'b1;
                rdata    = 32'haaaa0001;
                saw      = 1;
            end
            #1;
            @(negedge clk);
        end
        arready = 1'b0;
        rvalid  = 1'b0;
        chk("redir_first_read", saw, 1);
        #1;
        chk("redir_new_miss", {31'd0, stall_req}, 32'd1);
        chk("redir_new_not_valid", {31'd0, inst_valid_o}, 32'd0);
        rom_addr = 32'hbfc00004;
        #1;
        chk("redir_old_buffered", {31'd0, inst_valid_o}, 32'd1);
        chk("redir_old_data", inst_o, 32'haaaa0001);
        rom_en = 1'b0;
        fetch(32'h80000180, 32'hbbbb0002, 2'b00, 0, 0, 32'h00000180, 3, 1'b0);

        // Bus error response, then a clean word
        fetch(32'h00001000, 32'h0badc0de, 2'b10, 0, 0, 32'h00001000, 3, ERR_EXP);
        fetch(32'h00001004, 32'h00000000, 2'b00, 1, 1, 32'h00001004, 5, 1'b0);

        // Reset while in ADDR
        @(negedge clk);
        rom_en   = 1'b1;
        rom_addr = 32'hbfc00000;
        saw = 0;
        for (int c = 0; c < 10 && saw == 0; c++) begin
            #1;
            if (arvalid) saw = 1;
            else @(negedge clk);
        end
        chk("rst_mid_reach_addr", saw, 1);
        rst    = 1'b0;
        rom_en = 1'b0;
        #1;
        chk("rst_mid_arvalid", {31'd0, arvalid}, 32'd0);
        chk("rst_mid_rready", {31'd0, rready}, 32'd0);
        chk("rst_mid_araddr", araddr, 32'd0);
        chk("rst_mid_inst_o", inst_o, 32'd0);
        repeat (2) @(negedge clk);
        rst      = 1'b1;
        rom_en   = 1'b1;
        rom_addr = 32'h00001004;
        #1;
        chk("rst_tag_invalid", {31'd0, stall_req}, 32'd1);
        rom_en = 1'b0;
        fetch(32'hbfc00000, 32'h3c080001, 2'b00, 0, 0, 32'h1fc00000, 3, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
